phy_tx_ctrl: RTL
================

# phy_tx_ctrl

Link-level sequencer in front of the PHY TX datapath. It brings the transmit link up with a fixed train of COM ordered-set words, then forwards 32-bit words from the upstream source through a valid/ready handshake. It fills idle cycles with IDL words and inserts one SKP word after every SKP_INTERVAL words. Its tx_data/tx_valid outputs drive the 32-bit word input and valid of the TX byte-striping datapath; everything runs on the word clock clk_2f.

## Interface
- TS_COUNT, 16 — number of COM words emitted during training; must be ≥1.
- SKP_INTERVAL, 64 — ACTIVE-state words between SKP insertions; must be ≥2.
- clk_2f  in  1  word clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- link_en  in  1  level enable; high requests link bring-up, low forces the link down.
- src_data  in  32  upstream word.
- src_valid  in  1  src_data valid.
- src_ready  out  1  combinational; transfer on the clock edge where src_valid && src_ready.
- tx_data  out  32  registered word to the TX datapath.
- tx_valid  out  1  registered valid to the TX datapath.
- link_up  out  1  registered; high in ACTIVE and SKIP.

## Operation
- Symbol words:
  - COM = 32'hBCBC_BCBC
  - IDL = 32'h7C7C_7C7C
  - SKP = 32'h1C1C_1C1C
- States and encoding:
  - DISABLED = 2'b00
  - TRAIN = 2'b01
  - ACTIVE = 2'b10
  - SKIP = 2'b11
- Edge actions: at each edge the registered outputs are loaded from the current state, then the state transitions.
- DISABLED: load tx_data=0, tx_valid=0. If link_en=1, go to TRAIN with ts_cnt=0.
- TRAIN: load COM, tx_valid=1, ts_cnt+1. At the edge where ts_cnt==TS_COUNT-1, go to ACTIVE with skp_cnt=0.
- ACTIVE: load tx_valid=1.
  - On a transfer, load tx_data=src_data; otherwise load IDL.
  - skp_cnt+1 every edge.
  - At the edge where skp_cnt==SKP_INTERVAL-1, go to SKIP.
- SKIP: load SKP, tx_valid=1, skp_cnt=0, then return to ACTIVE.
- src_ready = (state==ACTIVE) && link_en && !reset. Upstream words are never accepted and then dropped.
- link_en=0 in any state except DISABLED: at that edge load tx_data=0, tx_valid=0, link_up=0, clear both counters, go to DISABLED. This takes priority over all other transitions, including the TRAIN→ACTIVE transition and SKIP.
- Counters: ts_cnt is $clog2(TS_COUNT+1) bits, skp_cnt is $clog2(SKP_INTERVAL) bits. Both are unsigned, compared for equality, and never wrap past their terminal value.

## Timing
- Reset values: state=DISABLED, tx_data=0, tx_valid=0, link_up=0, ts_cnt=0, skp_cnt=0. src_ready=0 while reset is high.
- reset dominates link_en. Reset asserted mid-operation has the same effect at that edge as link_en dropping.
- Bring-up: link_en is first sampled high at edge k.
  - Edges k+1 … k+TS_COUNT load COM, so exactly TS_COUNT COM words appear.
  - link_up is set at edge k+TS_COUNT.
  - src_ready first rises in the cycle after edge k+TS_COUNT.
- Data latency is 1 cycle: a word accepted at edge n appears on tx_data after edge n, for exactly one cycle.
- SKP cadence: exactly SKP_INTERVAL data/IDL words, then one SKP word. src_ready is low only during the SKP cycle. The period is SKP_INTERVAL+1 words.
- tx_valid is continuously high from the first COM until the link goes down.

## Structure
- Shared package phy_pkg holds:
  - the COM/IDL/SKP byte and word constants, reused by the RX alignment and decode blocks;
  - the 2-bit state typedef and encodings.
- No sub-module. The FSM, the two counters and the output registers sit in one module.

## Test plan
Bench uses TS_COUNT=4, SKP_INTERVAL=8.
- Reset: hold reset 3 cycles with link_en=1 → tx_valid=0, tx_data=0, link_up=0, src_ready=0 throughout. The first COM appears 2 edges after reset deasserts.
- Training: raise link_en → exactly 4 consecutive words 32'hBCBC_BCBC, then link_up=1. src_ready goes high in the following cycle.
- Streaming with SKP: continuous src_valid with words 32'hFFDD_FFDD, 32'hEEAA_EEAA, 32'hDDFF_AABB, 32'hCABF_FABC repeating → each word appears one cycle after acceptance. After every 8 words, one 32'h1C1C_1C1C appears with src_ready=0 in that cycle. No word is lost or duplicated.
- Idle fill: src_valid low for 3 ACTIVE cycles → three 32'h7C7C_7C7C words, still counted toward the SKP interval.
- Link drop mid-TRAIN and mid-ACTIVE: link_en=0 after 2 COM words, and again while a word is offered.
  - tx_valid=0 and link_up=0 at the next edge.
  - src_ready is low in that cycle and the offered word is not consumed.
  - Re-enabling restarts with 4 full COM words.
- Drop during SKIP: link_en=0 in the SKIP cycle → DISABLED at that edge with no SKP output.

Source files
------------

// File: rtl/phy_pkg.sv
// Shared PHY symbol constants and link state encoding, used by the TX
// sequencer and by the RX alignment/decode blocks.
package phy_pkg;

    // Ordered-set byte values
    localparam logic [7:0] COM_BYTE = 8'hBC;
    localparam logic [7:0] IDL_BYTE = 8'h7C;
    localparam logic [7:0] SKP_BYTE = 8'h1C;

    // Full 32-bit symbol words (the byte repeated in every lane)
    localparam logic [31:0] COM_WORD = {4{COM_BYTE}};
    localparam logic [31:0] IDL_WORD = {4{IDL_BYTE}};
    localparam logic [31:0] SKP_WORD = {4{SKP_BYTE}};

    // Link sequencer state
    typedef enum logic [1:0] {
        ST_DISABLED = 2'b00,
        ST_TRAIN    = 2'b01,
        ST_ACTIVE   = 2'b10,
        ST_SKIP     = 2'b11
    } link_state_t;

endpackage : phy_pkg

// File: rtl/phy_tx_ctrl.sv
// Link-level TX sequencer: COM training train, then data forwarding with
// IDL fill and periodic SKP insertion, feeding the TX byte-striping path.
module phy_tx_ctrl
    import phy_pkg::*;
#(
    parameter int TS_COUNT     = 16,
    parameter int SKP_INTERVAL = 64
) (
    input  logic        clk_2f,
    input  logic        reset,
    input  logic        link_en,
    input  logic [31:0] src_data,
    input  logic        src_valid,
    output logic        src_ready,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    output logic        link_up
);

    localparam int TS_W  = $clog2(TS_COUNT + 1);
    localparam int SKP_W = $clog2(SKP_INTERVAL);

    // Terminal counter values at which the state advances
    localparam logic [TS_W-1:0]  TS_LAST  = TS_W'(TS_COUNT - 1);
    localparam logic [SKP_W-1:0] SKP_LAST = SKP_W'(SKP_INTERVAL - 1);

    link_state_t        state_reg;
    link_state_t        state_next;
    logic [TS_W-1:0]    ts_cnt_reg;
    logic [TS_W-1:0]    ts_cnt_next;
    logic [SKP_W-1:0]   skp_cnt_reg;
    logic [SKP_W-1:0]   skp_cnt_next;
    logic [31:0]        tx_data_reg;
    logic [31:0]        tx_data_next;
    logic               tx_valid_reg;
    logic               tx_valid_next;
    logic               link_up_reg;
    logic               link_up_next;
    logic               xfer;

    // Upstream is only accepted in ACTIVE while the link is staying up, so a
    // word offered at the edge the link drops is never consumed.
    assign src_ready = (state_reg == ST_ACTIVE) && link_en && !reset;
    assign xfer      = src_valid && src_ready;

    // State register
    always_ff @(posedge clk_2f) begin
        if (reset) begin
            state_reg <= ST_DISABLED;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; link_en low overrides every other transition
    always_comb begin
        state_next = state_reg;
        if (!link_en) begin
            state_next = ST_DISABLED;
        end else begin
            unique case (state_reg)
                ST_DISABLED: state_next = ST_TRAIN;
                ST_TRAIN: begin
                    if (ts_cnt_reg == TS_LAST) begin
                        state_next = ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (skp_cnt_reg == SKP_LAST) begin
                        state_next = ST_SKIP;
                    end
                end
                ST_SKIP:     state_next = ST_ACTIVE;
                default:     state_next = ST_DISABLED;
            endcase
        end
    end

    // Output and counter loads, taken from the current state
    always_comb begin
        tx_data_next  = 32'h0;
        tx_valid_next = 1'b0;
        ts_cnt_next   = ts_cnt_reg;
        skp_cnt_next  = skp_cnt_reg;
        if (!link_en) begin
            ts_cnt_next  = '0;
            skp_cnt_next = '0;
        end else begin
            unique case (state_reg)
                ST_DISABLED: begin
                    ts_cnt_next = '0;
                end
                ST_TRAIN: begin
                    tx_data_next  = COM_WORD;
                    tx_valid_next = 1'b1;
                    // Ends at TS_COUNT and is cleared on the next bring-up
                    ts_cnt_next   = ts_cnt_reg + TS_W'(1);
                    if (ts_cnt_reg == TS_LAST) begin
                        skp_cnt_next = '0;
                    end
                end
                ST_ACTIVE: begin
                    tx_data_next  = xfer ? src_data : IDL_WORD;
                    tx_valid_next = 1'b1;
                    // Terminal count goes straight back to zero rather than
                    // wrapping; SKIP clears it again anyway.
                    skp_cnt_next  = (skp_cnt_reg == SKP_LAST) ? '0
                                                              : skp_cnt_reg + SKP_W'(1);
                end
                ST_SKIP: begin
                    tx_data_next  = SKP_WORD;
                    tx_valid_next = 1'b1;
                    skp_cnt_next  = '0;
                end
                default: begin
                    ts_cnt_next  = '0;
                    skp_cnt_next = '0;
                end
            endcase
        end
        link_up_next = (state_next == ST_ACTIVE) || (state_next == ST_SKIP);
    end

    // Output and counter registers
    always_ff @(posedge clk_2f) begin
        if (reset) begin
            ts_cnt_reg   <= '0;
            skp_cnt_reg  <= '0;
            tx_data_reg  <= 32'h0;
            tx_valid_reg <= 1'b0;
            link_up_reg  <= 1'b0;
        end else begin
            ts_cnt_reg   <= ts_cnt_next;
            skp_cnt_reg  <= skp_cnt_next;
            tx_data_reg  <= tx_data_next;
            tx_valid_reg <= tx_valid_next;
            link_up_reg  <= link_up_next;
        end
    end

    assign tx_data  = tx_data_reg;
    assign tx_valid = tx_valid_reg;
    assign link_up  = link_up_reg;

endmodule : phy_tx_ctrl
